// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter between the drawing engines and a single-port frame-buffer SRAM.
// Requests are issued in acceptance order. Read data is broadcast to all engines with a one-hot tag.
module gfx_mem_arbiter #(
    parameter  int unsigned NUM_ENG = 5,
    parameter  int unsigned ADDR_W  = 16,
    parameter  int unsigned DATA_W  = 32,
    localparam int unsigned WBEN_W  = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_ENG*DATA_W-1:0]   eng_in_data,
    input  logic [NUM_ENG*ADDR_W-1:0]   eng_in_addr,
    input  logic [NUM_ENG*WBEN_W-1:0]   eng_in_wben,
    input  logic [NUM_ENG-1:0]          eng_in_op,
    input  logic [NUM_ENG-1:0]          eng_in_rts,
    output logic [NUM_ENG-1:0]          eng_out_rtr,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [WBEN_W-1:0]           mem_wben,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [DATA_W-1:0]           bcast_out_data,
    output logic                        bcast_out_xfc,
    output logic [NUM_ENG-1:0]          bcast_out_sel
);

    localparam int unsigned PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [NUM_ENG-1:0] grant_oh;
    int unsigned        cand;
    logic [PTR_W-1:0]   cand_idx;

    logic [DATA_W-1:0]  data_arr [NUM_ENG];
    logic [ADDR_W-1:0]  addr_arr [NUM_ENG];
    logic [WBEN_W-1:0]  wben_arr [NUM_ENG];

    logic [DATA_W-1:0]  sel_data;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WBEN_W-1:0]  sel_wben;
    logic               sel_op;

    logic [NUM_ENG-1:0] s1_tag;
    logic               s2_vld;
    logic [NUM_ENG-1:0] s2_tag;

    // Unpack the per-engine request slices.
    for (genvar i = 0; i < NUM_ENG; i++) begin : g_slice
        assign data_arr[i] = eng_in_data[i*DATA_W +: DATA_W];
        assign addr_arr[i] = eng_in_addr[i*ADDR_W +: ADDR_W];
        assign wben_arr[i] = eng_in_wben[i*WBEN_W +: WBEN_W];
    end

    // First requester at or above rr_ptr, wrapping; nothing is granted during reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_ENG) begin
                cand = cand - NUM_ENG;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_vld && eng_in_rts[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (rst) begin
            grant_vld = 1'b0;
        end
    end

    assign grant_oh    = grant_vld ? (NUM_ENG'(1) << grant_idx) : '0;
    assign eng_out_rtr = grant_oh;

    assign ptr_nxt  = (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign sel_data = data_arr[grant_idx];
    assign sel_addr = addr_arr[grant_idx];
    assign sel_wben = wben_arr[grant_idx];
    assign sel_op   = eng_in_op[grant_idx];

    // Round-robin pointer moves just past the engine that transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= ptr_nxt;
        end
    end

    // Request stage: the accepted request drives the SRAM port on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wben  <= '0;
            s1_tag    <= '0;
        end else begin
            mem_en <= grant_vld;
            mem_we <= grant_vld & sel_op;
            if (grant_vld) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_op ? sel_data : '0;
                mem_wben  <= sel_op ? sel_wben : '0;
                s1_tag    <= grant_oh;
            end
        end
    end

    // Return stage: SRAM read data arrives one cycle after the strobe and is broadcast the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld         <= 1'b0;
            s2_tag         <= '0;
            bcast_out_data <= '0;
            bcast_out_xfc  <= 1'b0;
            bcast_out_sel  <= '0;
        end else begin
            s2_vld <= mem_en & ~mem_we;
            if (mem_en) begin
                s2_tag <= s1_tag;
            end
            bcast_out_xfc <= s2_vld;
            bcast_out_sel <= s2_vld ? s2_tag : '0;
            if (s2_vld) begin
                bcast_out_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Randomized and directed bench for gfx_mem_arbiter against a transaction-level reference model.
// The model applies accepted requests in order to a reference memory and schedules the expected broadcasts.
module tb_gfx_mem_arbiter;

    localparam int unsigned NUM_ENG = 5;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WBEN_W  = DATA_W / 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_ENG*DATA_W-1:0] eng_in_data;
    logic [NUM_ENG*ADDR_W-1:0] eng_in_addr;
    logic [NUM_ENG*WBEN_W-1:0] eng_in_wben;
    logic [NUM_ENG-1:0]        eng_in_op;
    logic [NUM_ENG-1:0]        eng_in_rts;
    logic [NUM_ENG-1:0]        eng_out_rtr;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [WBEN_W-1:0]         mem_wben;
    logic [DATA_W-1:0]         mem_rdata;
    logic [DATA_W-1:0]         bcast_out_data;
    logic                      bcast_out_xfc;
    logic [NUM_ENG-1:0]        bcast_out_sel;

    gfx_mem_arbiter #(.NUM_ENG(NUM_ENG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .eng_in_data(eng_in_data), .eng_in_addr(eng_in_addr), .eng_in_wben(eng_in_wben),
        .eng_in_op(eng_in_op), .eng_in_rts(eng_in_rts), .eng_out_rtr(eng_out_rtr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wben(mem_wben), .mem_rdata(mem_rdata),
        .bcast_out_data(bcast_out_data), .bcast_out_xfc(bcast_out_xfc), .bcast_out_sel(bcast_out_sel)
    );

    always #5 clk = ~clk;

    // Frame-buffer SRAM: synchronous single port, read data one cycle after the strobe.
    logic [DATA_W-1:0] sram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < WBEN_W; b++)
                    if (mem_wben[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    typedef struct packed {
        int unsigned       cyc;
        logic [DATA_W-1:0] data;
        logic [NUM_ENG-1:0] sel;
    } bc_t;

    logic [DATA_W-1:0] ref_mem [0:65535];
    bc_t               exp_q[$];
    int unsigned       cyc;
    int                m_ptr;
    logic              exp_en, exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic [WBEN_W-1:0] exp_wben;
    logic [DATA_W-1:0] last_bc_data;
    logic [NUM_ENG-1:0] last_rtr;
    int                checks;
    int                failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_req();
        eng_in_data = '0;
        eng_in_addr = '0;
        eng_in_wben = '0;
        eng_in_op   = '0;
        eng_in_rts  = '0;
    endtask

    task automatic set_req(input int e, input logic op, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [WBEN_W-1:0] w);
        eng_in_rts[e]                 = 1'b1;
        eng_in_op[e]                  = op;
        eng_in_addr[e*ADDR_W +: ADDR_W] = a;
        eng_in_data[e*DATA_W +: DATA_W] = d;
        eng_in_wben[e*WBEN_W +: WBEN_W] = w;
    endtask

    task automatic model_reset();
        m_ptr        = 0;
        exp_en       = 1'b0;
        exp_we       = 1'b0;
        exp_addr     = '0;
        exp_wdata    = '0;
        exp_wben     = '0;
        last_bc_data = '0;
        exp_q.delete();
    endtask

    // One clock cycle: check everything at the falling edge, then advance the model.
    task automatic tick();
        int g;
        bc_t e;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [WBEN_W-1:0] w;
        @(negedge clk);
        last_rtr = eng_out_rtr;
        check("mem_en", 64'(mem_en), 64'(exp_en));
        check("mem_we", 64'(mem_we), 64'(exp_we));
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        check("mem_wben", 64'(mem_wben), 64'(exp_wben));
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("bc_xfc", 64'(bcast_out_xfc), 64'(1));
            check("bc_data", 64'(bcast_out_data), 64'(e.data));
            check("bc_sel", 64'(bcast_out_sel), 64'(e.sel));
            last_bc_data = e.data;
        end else begin
            check("bc_xfc_idle", 64'(bcast_out_xfc), 64'(0));
            check("bc_sel_idle", 64'(bcast_out_sel), 64'(0));
            check("bc_data_hold", 64'(bcast_out_data), 64'(last_bc_data));
        end
        g = -1;
        for (int k = 0; k < NUM_ENG; k++) begin
            int c;
            c = (m_ptr + k) % NUM_ENG;
            if (g < 0 && eng_in_rts[c]) g = c;
        end
        check("rtr", 64'(eng_out_rtr), (g < 0) ? 64'(0) : (64'(1) << g));
        if (g >= 0) begin
            a = eng_in_addr[g*ADDR_W +: ADDR_W];
            d = eng_in_data[g*DATA_W +: DATA_W];
            w = eng_in_wben[g*WBEN_W +: WBEN_W];
            m_ptr    = (g + 1) % NUM_ENG;
            exp_en   = 1'b1;
            exp_we   = eng_in_op[g];
            exp_addr = a;
            if (eng_in_op[g]) begin
                exp_wdata = d;
                exp_wben  = w;
                for (int b = 0; b < WBEN_W; b++)
                    if (w[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_wdata = '0;
                exp_wben  = '0;
                e.cyc  = cyc + 3;
                e.data = ref_mem[a];
                e.sel  = NUM_ENG'(1) << g;
                exp_q.push_back(e);
            end
        end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n cycles checking that every output is zero, then release with the model reset.
    task automatic reset_cycles(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_rtr", 64'(eng_out_rtr), 64'(0));
            check("rst_mem_en", 64'(mem_en), 64'(0));
            check("rst_mem_we", 64'(mem_we), 64'(0));
            check("rst_mem_addr", 64'(mem_addr), 64'(0));
            check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
            check("rst_mem_wben", 64'(mem_wben), 64'(0));
            check("rst_bc_data", 64'(bcast_out_data), 64'(0));
            check("rst_bc_xfc", 64'(bcast_out_xfc), 64'(0));
            check("rst_bc_sel", 64'(bcast_out_sel), 64'(0));
            cyc++;
            @(posedge clk);
            #1;
        end
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] tmp;
        logic [NUM_ENG-1:0] rr_seq [6];
        int ptr_before;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        mem_rdata = '0;
        rst       = 1'b1;
        clear_req();
        for (int i = 0; i < 65536; i++) begin
            tmp        = $urandom;
            sram[i]    = tmp;
            ref_mem[i] = tmp;
        end
        model_reset();
        #1;
        reset_cycles(3);

        // Single write then read from engine 1.
        set_req(1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        tick();
        check("wr_grant", 64'(last_rtr), 64'(5'b00010));
        check("wr_mem_we", 64'(mem_we), 64'(1));
        check("wr_mem_addr", 64'(mem_addr), 64'(16'h0010));
        clear_req();
        set_req(1, 1'b0, 16'h0010, 32'h0, 4'h0);
        tick();
        clear_req();
        tick();
        tick();
        check("rd_xfc", 64'(bcast_out_xfc), 64'(1));
        check("rd_data", 64'(bcast_out_data), 64'(32'hDEADBEEF));
        check("rd_sel", 64'(bcast_out_sel), 64'(5'b00010));
        tick();
        check("rd_xfc_one", 64'(bcast_out_xfc), 64'(0));

        // Byte enables merge into the previous word.
        set_req(0, 1'b1, 16'h0020, 32'h11223344, 4'hF);
        tick();
        set_req(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'h5);
        tick();
        set_req(0, 1'b0, 16'h0020, 32'h0, 4'h0);
        tick();
        clear_req();
        tick();
        tick();
        check("be_data", 64'(bcast_out_data), 64'(32'h11BB33DD));

        // Zero-enable write is issued but leaves the word unchanged.
        set_req(4, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'h0);
        tick();
        check("zbe_we", 64'(mem_we), 64'(1));
        check("zbe_wben", 64'(mem_wben), 64'(0));
        clear_req();
        set_req(4, 1'b0, 16'h0020, 32'h0, 4'h0);
        tick();
        clear_req();
        tick();
        tick();
        check("zbe_data", 64'(bcast_out_data), 64'(32'h11BB33DD));

        // Pipelined reads from engine 3 yield contiguous strobes.
        for (int i = 0; i < 3; i++) begin
            clear_req();
            set_req(3, 1'b0, ADDR_W'(i), 32'h0, 4'h0);
            tick();
        end
        clear_req();
        for (int i = 0; i < 3; i++) begin
            check("pipe_xfc", 64'(bcast_out_xfc), 64'(1));
            check("pipe_sel", 64'(bcast_out_sel), 64'(5'b01000));
            tick();
        end
        check("pipe_end", 64'(bcast_out_xfc), 64'(0));
        tick();
        tick();

        // Round robin among engines 0, 2, 4 starting from a fresh pointer.
        reset_cycles(2);
        rr_seq[0] = 5'b00001; rr_seq[1] = 5'b00100; rr_seq[2] = 5'b10000;
        rr_seq[3] = 5'b00001; rr_seq[4] = 5'b00100; rr_seq[5] = 5'b10000;
        set_req(0, 1'b0, 16'h0004, 32'h0, 4'h0);
        set_req(2, 1'b0, 16'h0005, 32'h0, 4'h0);
        set_req(4, 1'b0, 16'h0006, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_grant", 64'(last_rtr), 64'(rr_seq[i]));
        end
        clear_req();
        for (int i = 0; i < 4; i++) tick();

        // Reset pulsed while a read is in flight.
        set_req(2, 1'b0, 16'h0003, 32'h0, 4'h0);
        tick();
        clear_req();
        set_req(1, 1'b0, 16'h0001, 32'h0, 4'h0);
        set_req(3, 1'b0, 16'h0002, 32'h0, 4'h0);
        reset_cycles(2);
        tick();
        check("post_rst_grant", 64'(last_rtr), 64'(5'b00010));
        clear_req();
        for (int i = 0; i < 5; i++) tick();

        // Idle: pointer must not drift.
        ptr_before = m_ptr;
        for (int i = 0; i < 20; i++) tick();
        for (int e = 0; e < NUM_ENG; e++) set_req(e, 1'b0, ADDR_W'(e), 32'h0, 4'h0);
        tick();
        check("idle_ptr", 64'(last_rtr), 64'(1) << ptr_before);
        clear_req();

        // Randomized traffic over a small address window to exercise hazards.
        for (int i = 0; i < 600; i++) begin
            clear_req();
            for (int e = 0; e < NUM_ENG; e++)
                if ($urandom_range(1, 0) == 1)
                    set_req(e, 1'($urandom_range(1, 0)), ADDR_W'($urandom_range(7, 0)),
                            $urandom, WBEN_W'($urandom_range(15, 0)));
            tick();
        end
        clear_req();
        for (int i = 0; i < 6; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
